// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus arbiter
package bus_pkg;

    localparam int N_REQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } arb_state_t;

    // Never narrower than one bit, so a single-requester build still has an id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational rotate-priority encoder
// The search starts at ptr and wraps; the first unmasked request wins.
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!valid && req[j] && !mask[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter, no preemption, 1-cycle turnaround
// Optional watchdog with requester masking is enabled by defining BUS_ARB_WATCHDOG_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic [N_REQ-1:0]            DMA,
    input  logic                        BUS_ready,
    output logic [N_REQ-1:0]            grant,
    output logic [id_width(N_REQ)-1:0]  owner_id,
    output logic                        bus_busy,
    output logic                        timeout_err,
    output logic [id_width(N_REQ)-1:0]  err_id,
    input  logic                        err_clr
);

    localparam int ID_W = id_width(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] elig_mask;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             owner_req;

    assign owner_req = DMA[owner_id];

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] wd_cnt;
    logic [N_REQ-1:0] mask;
    logic             fire;

    // A beat completing in the last allowed cycle counts as progress.
    assign fire      = (state == OWN) && owner_req && !BUS_ready &&
                       (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign elig_mask = mask;
`else
    logic unused_ok;

    assign unused_ok   = BUS_ready ^ err_clr ^ (TIMEOUT > 0);
    assign elig_mask   = '0;
    assign timeout_err = 1'b0;
    assign err_id      = '0;
`endif

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req   (DMA),
        .mask  (elig_mask),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            bus_busy <= 1'b0;
            owner_id <= '0;
`ifdef BUS_ARB_WATCHDOG_EN
            timeout_err <= 1'b0;
            err_id      <= '0;
            wd_cnt      <= '0;
            mask        <= '0;
`endif
        end else begin
`ifdef BUS_ARB_WATCHDOG_EN
            // A low request releases its mask; a watchdog event below overrides.
            mask <= mask & DMA;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= OWN;
                        grant    <= ONE_HOT0 << pick_idx;
                        owner_id <= pick_idx;
                        bus_busy <= 1'b1;
                        ptr      <= ID_W'((int'(pick_idx) + 1) % N_REQ);
`ifdef BUS_ARB_WATCHDOG_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        state    <= TURN;
                        grant    <= '0;
                        bus_busy <= 1'b0;
                    end
`ifdef BUS_ARB_WATCHDOG_EN
                    else if (fire) begin
                        state         <= TURN;
                        grant         <= '0;
                        bus_busy      <= 1'b0;
                        timeout_err   <= 1'b1;
                        err_id        <= owner_id;
                        mask[owner_id] <= 1'b1;
                    end else if (BUS_ready) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] DMA = 8'h00;
    logic       BUS_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] grant;
    logic [2:0] owner_id;
    logic [2:0] err_id;
    logic       bus_busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(
        .N_REQ   (8),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .DMA         (DMA),
        .BUS_ready   (BUS_ready),
        .grant       (grant),
        .owner_id    (owner_id),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err),
        .err_id      (err_id),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        DMA = 8'h00;
        BUS_ready = 1'b0;
        err_clr = 1'b0;
        tick();
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        #2;
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant: got %h want %h", grant, 8'h00); end
        n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
        n_checks++; if (owner_id !== 3'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
        n_checks++; if (timeout_err !== 1'b0 || err_id !== 3'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", timeout_err, err_id); end
        tick();
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        DMA = 8'h01;
        tick();
        n_checks++; if (grant !== 8'h01 || owner_id !== 3'd0) begin n_fail++; $display("FAIL single_grant: got %h/%0d want 01/0", grant, owner_id); end
        n_checks++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus_busy); end
        DMA = 8'h00;
        tick();
        n_checks++; if (grant !== 8'h00 || bus_busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got %h/%b want 00/0", grant, bus_busy); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        do_reset();
        DMA = 8'h81;
        for (int k = 0; k < 3; k++) begin
            exp = (k % 2 == 0) ? 8'h01 : 8'h80;
            tick();
            n_checks++; if (grant !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %h want %h", k, grant, exp); end
            tick();
            tick();
            n_checks++; if (grant !== exp) begin n_fail++; $display("FAIL rr_hold[%0d]: got %h want %h", k, grant, exp); end
            DMA = 8'h81 & ~exp;
            tick();
            n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rr_gap1[%0d]: got %h want 00", k, grant); end
            DMA = 8'h81;
            tick();
            n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rr_gap2[%0d]: got %h want 00", k, grant); end
        end
        DMA = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_no_preempt();
        do_reset();
        DMA = 8'h04;
        tick();
        n_checks++; if (grant !== 8'h04 || owner_id !== 3'd2) begin n_fail++; $display("FAIL np_grant: got %h/%0d want 04/2", grant, owner_id); end
        DMA = 8'h24;
        tick();
        tick();
        tick();
        n_checks++; if (grant !== 8'h04) begin n_fail++; $display("FAIL np_hold: got %h want 04", grant); end
        DMA = 8'h20;
        tick();
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL np_turn: got %h want 00", grant); end
        tick();
        tick();
        n_checks++; if (grant !== 8'h20 || owner_id !== 3'd5) begin n_fail++; $display("FAIL np_next: got %h/%0d want 20/5", grant, owner_id); end
        DMA = 8'h22;
        tick();
        tick();
        DMA = 8'h20;
        tick();
        DMA = 8'h00;
        tick();
        tick();
        tick();
        tick();
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL lost_pulse: got %h want 00", grant); end
    endtask

    task automatic test_zero_idle();
        do_reset();
        DMA = 8'h01;
        tick();
        DMA = 8'h00;
        tick();
        tick();
        tick();
        tick();
        n_checks++; if (grant !== 8'h00 || bus_busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got %h/%b want 00/0", grant, bus_busy); end
        DMA = 8'h81;
        tick();
        n_checks++; if (grant !== 8'h80) begin n_fail++; $display("FAIL zero_ptr_kept: got %h want 80", grant); end
        DMA = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        DMA = 8'h10;
        tick();
        n_checks++; if (grant !== 8'h10) begin n_fail++; $display("FAIL rst_own_grant: got %h want 10", grant); end
        #3;
        clr_n = 1'b0;
        #1;
        n_checks++; if (grant !== 8'h00 || bus_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: got %h/%b want 00/0", grant, bus_busy); end
        DMA = 8'h11;
        tick();
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rst_held: got %h want 00", grant); end
        clr_n = 1'b1;
        tick();
        n_checks++; if (grant !== 8'h01 || owner_id !== 3'd0) begin n_fail++; $display("FAIL rst_favour0: got %h/%0d want 01/0", grant, owner_id); end
        DMA = 8'h00;
        tick();
        tick();
    endtask

`ifdef BUS_ARB_WATCHDOG_EN
    task automatic test_watchdog_timeout();
        do_reset();
        DMA = 8'h08;
        tick();
        n_checks++; if (grant !== 8'h08 || owner_id !== 3'd3) begin n_fail++; $display("FAIL wd_grant: got %h/%0d want 08/3", grant, owner_id); end
        repeat (63) tick();
        n_checks++; if (grant !== 8'h08 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_before: got %h/%b want 08/0", grant, timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL wd_drop: got %h want 00", grant); end
        n_checks++; if (timeout_err !== 1'b1 || err_id !== 3'd3) begin n_fail++; $display("FAIL wd_err: got %b/%0d want 1/3", timeout_err, err_id); end
        repeat (5) tick();
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL wd_masked: got %h want 00", grant); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_clr: got %b want 0", timeout_err); end
        DMA = 8'h00;
        tick();
        DMA = 8'h08;
        tick();
        n_checks++; if (grant !== 8'h08) begin n_fail++; $display("FAIL wd_regrant: got %h want 08", grant); end
        DMA = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_watchdog_release_same_cycle();
        do_reset();
        DMA = 8'h08;
        tick();
        repeat (63) tick();
        DMA = 8'h00;
        tick();
        n_checks++; if (grant !== 8'h00 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_race: got %h/%b want 00/0", grant, timeout_err); end
        tick();
        DMA = 8'h08;
        tick();
        n_checks++; if (grant !== 8'h08) begin n_fail++; $display("FAIL wd_race_unmasked: got %h want 08", grant); end
        DMA = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_watchdog_keepalive();
        logic ok;
        do_reset();
        DMA = 8'h08;
        tick();
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            BUS_ready = (i % 10 == 9);
            tick();
            if (grant !== 8'h08 || timeout_err !== 1'b0) ok = 1'b0;
        end
        BUS_ready = 1'b0;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wd_keepalive: got %h/%b want 08/0 throughout", grant, timeout_err); end
        DMA = 8'h00;
        tick();
        tick();
    endtask
`else
    task automatic test_no_watchdog();
        logic ok;
        do_reset();
        DMA = 8'h08;
        tick();
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            err_clr = (i % 7 == 0);
            tick();
            if (grant !== 8'h08 || timeout_err !== 1'b0 || err_id !== 3'd0) ok = 1'b0;
        end
        err_clr = 1'b0;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL no_wd_hold: got %h/%b/%0d want 08/0/0 throughout", grant, timeout_err, err_id); end
        DMA = 8'h00;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_zero_idle();
        test_reset_mid_own();
`ifdef BUS_ARB_WATCHDOG_EN
        test_watchdog_timeout();
        test_watchdog_release_same_cycle();
        test_watchdog_keepalive();
`else
        test_no_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 8, meaning the number of bus requesters (DMA lines).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of granted cycles allowed without a BUS_ready pulse.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port DMA, input, N_REQ, meaning the per-requester bus request, held high for the whole transaction.
REQ-006 The block SHALL have port BUS_ready, input, 1, meaning the slave completion pulse for the current bus beat.
REQ-007 The block SHALL have port grant, output, N_REQ, meaning the one-hot or zero bus ownership vector.
REQ-008 The block SHALL have port owner_id, output, clog2(N_REQ), meaning the index of the current owner; valid only while bus_busy is high.
REQ-009 The block SHALL have port bus_busy, output, 1, meaning that grant is nonzero.
REQ-010 The block SHALL have port timeout_err, output, 1, meaning a sticky watchdog-fired flag.
REQ-011 The block SHALL have port err_id, output, clog2(N_REQ), meaning the owner index captured at the last watchdog event.
REQ-012 The block SHALL have port err_clr, input, 1, meaning a synchronous clear of timeout_err.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, OWN and TURN.
REQ-014 In IDLE with any eligible DMA bit set, the block SHALL select a winner at the next edge, enter OWN, and assert grant one-hot; request-to-grant latency is 1 cycle.
REQ-015 Winner selection SHALL be round-robin: search starts at index ptr and wraps modulo N_REQ; ptr updates to winner+1 (mod N_REQ) on each grant.
REQ-016 In OWN, grant SHALL be held while DMA[owner] is 1; other requests are ignored (no preemption).
REQ-017 When DMA[owner] is 0 in OWN, the block SHALL deassert grant at the next edge and enter TURN.
REQ-018 TURN SHALL last exactly 1 cycle with grant = 0 (bus turnaround), then go to IDLE; minimum gap between two grants is 2 cycles.
REQ-019 A DMA pulse that rises and falls while another requester owns the bus SHALL be lost, with no queuing.
REQ-020 bus_busy SHALL equal |grant, and grant SHALL never have more than one bit set.
REQ-021 A DMA bit for an index at or above N_REQ does not exist; a DMA vector of all zeros in IDLE SHALL keep the FSM in IDLE with ptr unchanged.

Reset
REQ-022 clr_n low SHALL asynchronously set state = IDLE, grant = 0, ptr = 0, bus_busy = 0, owner_id = 0, timeout_err = 0, err_id = 0, wd counter = 0, and mask = 0.
REQ-023 Reset asserted mid-OWN SHALL drop grant immediately, without a TURN cycle.
REQ-024 After clr_n rises, the first arbitration SHALL favour index 0.

Configuration
REQ-025 With BUS_ARB_WATCHDOG_EN defined: a counter SHALL clear on grant and on every BUS_ready in OWN, and increment otherwise.
REQ-026 With BUS_ARB_WATCHDOG_EN defined, when the counter reaches TIMEOUT-1 in OWN: the block SHALL force TURN, set timeout_err, capture err_id = owner, and set mask[owner].
REQ-027 With BUS_ARB_WATCHDOG_EN defined, a masked requester SHALL be ineligible until its DMA bit is seen low, which clears its mask bit.
REQ-028 If the owner drops DMA in the same cycle the watchdog fires, a normal release SHALL occur with no error.
REQ-029 If err_clr and a new timeout occur in the same cycle, the timeout SHALL win.
REQ-030 Without BUS_ARB_WATCHDOG_EN: there SHALL be no counter or mask, timeout_err and err_id SHALL be tied 0, and err_clr SHALL be ignored.

Structure
REQ-031 Package bus_pkg SHALL hold N_REQ_DEFAULT, the ID width function/constant, and the arb_state_t enum {IDLE, OWN, TURN}.
REQ-032 The block SHALL contain one sub-module, rr_pick: a combinational rotate-priority encoder that takes (req, mask, ptr) and returns (valid, idx).

Verification
REQ-033 Test: DMA=8'h01 from reset -> grant=8'h01 after 1 cycle and owner_id=0; DMA=0 -> grant=0 next cycle, with a 1-cycle TURN.
REQ-034 Test: DMA=8'h81 held continuously, each owner dropping after 3 cycles then re-raising -> grants alternate 8'h01, 8'h80, 8'h01 with 2-cycle gaps.
REQ-035 Test: owner 2 active and DMA[5] raised mid-transaction -> grant stays 8'h04 until DMA[2] falls, then grant=8'h20.
REQ-036 Test (watchdog): TIMEOUT=64, owner 3, BUS_ready never pulsed -> grant drops 64 cycles after grant, timeout_err=1, err_id=3; DMA[3] stays high and is not regranted until it toggles low.
REQ-037 Test (watchdog): owner 3 with BUS_ready every 10 cycles for 200 cycles -> no timeout.
REQ-038 Test: clr_n pulsed low while grant=8'h10 -> grant=0 asynchronously, and the next arbitration with DMA=8'h11 picks index 0.
